store_narrow: RTL and testbench

STORE_NARROW -- requirements
Module: store_narrow

---
 rtl/store_pkg.sv | 43 ++++
 rtl/store_lane_align.sv | 15 +
 rtl/store_narrow.sv | 94 +++++++++
 tb/tb_store_narrow.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared encodings, state enum and lane-mask helpers for the narrow store path.
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        DONE,
        ERR
    } st_state_e;

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } st_req_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return MASK_BYTE;
            SZ_HALF: return MASK_HALF;
            SZ_WORD: return MASK_WORD;
            default: return 4'b0000;
        endcase
    endfunction

    // True when the store's enabled bytes spill into the next word.
    function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] be;
        be = {4'b0000, lane_mask(size)} << off;
        return |be[7:4];
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places right-justified store data and its byte mask into a two-word window.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [63:0] wide_data,
    output logic [7:0]  wide_be
);

    assign wide_data = {32'h0, data} << {off, 3'b000};
    assign wide_be   = {4'b0000, lane_mask(size)} << off;

endmodule

// File: rtl/store_narrow.sv
// Converts byte/half/word stores into one or two word-aligned memory beats.
module store_narrow
    import store_pkg::*;
#(
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be
);

    st_state_e   state, state_nxt;
    st_req_t     req;
    logic [63:0] wide_data;
    logic [7:0]  wide_be;
    logic [31:0] beat_addr;
    logic        accept, reject;

    assign accept = st_valid && (state == IDLE);
    // Rejection is decided from the live request so ERR is reached one cycle after accept.
    assign reject = (st_size == SZ_RSVD) ||
                    ((ALLOW_MISALIGN == 0) && needs_split(st_size, st_addr[1:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      req <= '0;
        else if (accept) req <= '{size: st_size, addr: st_addr, data: st_data};
    end

    store_lane_align u_align (
        .size      (req.size),
        .off       (req.addr[1:0]),
        .data      (req.data),
        .wide_data (wide_data),
        .wide_be   (wide_be)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = reject ? ERR : BEAT0;
            BEAT0:    if (mem_gnt) state_nxt = (|wide_be[7:4]) ? BEAT1 : DONE;
            BEAT1:    if (mem_gnt) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            ERR:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign beat_addr = {req.addr[31:2], 2'b00};

    // Bus outputs are pure state/register decodes and idle at zero.
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        case (state)
            BEAT0: begin
                mem_req   = 1'b1;
                mem_addr  = beat_addr;
                mem_wdata = wide_data[31:0];
                mem_be    = wide_be[3:0];
            end
            BEAT1: begin
                mem_req   = 1'b1;
                mem_addr  = beat_addr + 32'd4;
                mem_wdata = wide_data[63:32];
                mem_be    = wide_be[7:4];
            end
            default: ;
        endcase
    end

    assign st_ready = (state == IDLE);
    assign st_done  = (state == DONE);
    assign st_err   = (state == ERR);

endmodule

// File: tb/tb_store_narrow.sv
// Directed and random stores checked against a byte-placement reference model.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0, st_valid2 = 1'b0;
    logic        mem_gnt = 1'b0, mem_gnt2 = 1'b0;
    logic [1:0]  st_size = 2'b00;
    logic [31:0] st_addr = '0, st_data = '0;
    logic        st_ready, st_done, st_err, mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        st_ready2, st_done2, st_err2, mem_req2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic [3:0]  mem_be2;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_a [2];
    logic [31:0] exp_d [2];
    logic [3:0]  exp_b [2];
    int          nb;

    always #5 clk = ~clk;

    store_narrow #(.ALLOW_MISALIGN(1)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
        .st_done(st_done), .st_err(st_err), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
    );

    store_narrow #(.ALLOW_MISALIGN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid2), .st_ready(st_ready2),
        .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
        .st_done(st_done2), .st_err(st_err2), .mem_req(mem_req2), .mem_gnt(mem_gnt2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_be(mem_be2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Each data byte k lands at byte position off+k of a two-word window;
    // only the first size bytes are enabled.
    task automatic model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int nbytes, pos;
        nbytes   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_a[0] = a & 32'hFFFF_FFFC;
        exp_a[1] = exp_a[0] + 32'd4;
        exp_d[0] = '0; exp_d[1] = '0;
        exp_b[0] = '0; exp_b[1] = '0;
        nb = 1;
        for (int k = 0; k < 4; k++) begin
            pos = int'(a[1:0]) + k;
            exp_d[pos / 4][8 * (pos % 4) +: 8] = d[8 * k +: 8];
            if (k < nbytes) begin
                exp_b[pos / 4][pos % 4] = 1'b1;
                if (pos >= 4) nb = 2;
            end
        end
    endtask

    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input int w0, input int w1);
        int w [2];
        w[0] = w0;
        w[1] = w1;
        model(sz, a, d);
        @(negedge clk);
        chk1("ready_idle", st_ready, 1'b1);
        st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d;
        mem_gnt = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        st_valid = 1'b0; st_size = 2'($urandom); st_addr = $urandom; st_data = $urandom;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i <= w[b]; i++) begin
                @(negedge clk);
                chk1("mem_req", mem_req, 1'b1);
                chk("mem_addr", mem_addr, exp_a[b]);
                chk("mem_wdata", mem_wdata, exp_d[b]);
                chk("mem_be", 32'(mem_be), 32'(exp_b[b]));
                chk1("busy_ready", st_ready, 1'b0);
                chk1("early_done", st_done, 1'b0);
                mem_gnt = (i == w[b]);
            end
        end
        @(negedge clk);
        chk1("st_done", st_done, 1'b1);
        chk1("done_req", mem_req, 1'b0);
        chk("done_addr", mem_addr, 32'h0);
        chk("done_wdata", mem_wdata, 32'h0);
        chk("done_be", 32'(mem_be), 32'h0);
        mem_gnt = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk1("done_pulse", st_done, 1'b0);
        chk1("ready_back", st_ready, 1'b1);
        mem_gnt = 1'b0;
    endtask

    initial begin
        #1;
        chk1("rst_ready", st_ready, 1'b1);
        chk1("rst_done", st_done, 1'b0);
        chk1("rst_err", st_err, 1'b0);
        chk1("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;

        do_store(2'b00, 32'h0000_1003, 32'hFFFF_FFAB, 0, 0);
        do_store(2'b10, 32'h0000_2002, 32'h1122_3344, 0, 0);
        do_store(2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 0);
        do_store(2'b10, 32'h0000_0040, $urandom, 3, 0);

        // Reserved size is rejected without a memory beat.
        @(negedge clk);
        st_valid = 1'b1; st_size = 2'b11; st_addr = $urandom; st_data = $urandom;
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk1("rsvd_err", st_err, 1'b1);
        chk1("rsvd_req", mem_req, 1'b0);
        chk1("rsvd_ready", st_ready, 1'b0);
        @(negedge clk);
        chk1("rsvd_err_pulse", st_err, 1'b0);
        chk1("rsvd_req2", mem_req, 1'b0);
        chk1("rsvd_ready_back", st_ready, 1'b1);

        // Misalign-rejecting instance: crossing word store errors.
        @(negedge clk);
        st_valid2 = 1'b1; st_size = 2'b10; st_addr = 32'h0000_0005; st_data = $urandom;
        @(posedge clk); #1;
        st_valid2 = 1'b0;
        @(negedge clk);
        chk1("mis_err", st_err2, 1'b1);
        chk1("mis_req", mem_req2, 1'b0);
        @(negedge clk);
        chk1("mis_err_pulse", st_err2, 1'b0);
        chk1("mis_ready", st_ready2, 1'b1);

        // Same instance: an unaligned byte that fits in one word still goes out.
        @(negedge clk);
        st_valid2 = 1'b1; st_size = 2'b00; st_addr = 32'h0000_0005; st_data = 32'h0000_005A;
        @(posedge clk); #1;
        st_valid2 = 1'b0;
        @(negedge clk);
        chk1("fit_req", mem_req2, 1'b1);
        chk("fit_addr", mem_addr2, 32'h0000_0004);
        chk("fit_wdata", mem_wdata2, 32'h0000_5A00);
        chk("fit_be", 32'(mem_be2), 32'h2);
        mem_gnt2 = 1'b1;
        @(negedge clk);
        mem_gnt2 = 1'b0;
        chk1("fit_done", st_done2, 1'b1);
        chk1("fit_noerr", st_err2, 1'b0);

        // Reset during the second beat of a split store.
        model(2'b10, 32'h0000_2002, 32'hCAFE_F00D);
        @(negedge clk);
        st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_2002; st_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk1("rm_beat0", mem_req, 1'b1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rm_beat1_addr", mem_addr, exp_a[1]);
        #2 rst_n = 1'b0;
        #1;
        chk1("rm_req", mem_req, 1'b0);
        chk("rm_addr", mem_addr, 32'h0);
        chk1("rm_ready", st_ready, 1'b1);
        chk1("rm_done", st_done, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk1("rm_no_done", st_done, 1'b0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        do_store(2'b01, 32'h0000_3001, $urandom, 0, 0);

        for (int n = 0; n < 40; n++) begin
            do_store(2'($urandom_range(0, 2)), $urandom, $urandom,
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
